// File: rtl/forth_cpu_if.sv
// Instruction-fetch and data-memory port bundle of the forth_cpu core.
// The master side is the CPU; the slave side is ROM/RAM/IO.
interface forth_cpu_if;
  logic [9:0]  iaddr;
  logic [15:0] idata;
  logic [7:0]  daddr;
  logic [15:0] ddata_write;
  logic [15:0] ddata_read;
  logic        dwrite;

  modport master (
    output iaddr, daddr, ddata_write, dwrite,
    input  idata, ddata_read
  );

  modport slave (
    input  iaddr, daddr, ddata_write, dwrite,
    output idata, ddata_read
  );
endinterface

// File: rtl/forth_cpu.sv
// J1-style 16-bit dual-stack Forth core: one instruction per clock, TOS kept in
// a register, parameter and return stacks held in small internal arrays.
module forth_cpu #(
  parameter int SP_BITS = 4
) (
  input logic         clk,
  input logic         reset,
  forth_cpu_if.master bus
);
  localparam int DEPTH = 2 ** SP_BITS;
  typedef logic [SP_BITS-1:0] ptr_t;
  typedef enum logic {ST_FETCH, ST_EXEC} state_t;

  logic [15:0] pstack [DEPTH];
  logic [15:0] rstack [DEPTH];

  state_t      state_q;
  logic [9:0]  ip_q, ip_d, ip_inc;
  logic [15:0] t_q, t_d;
  ptr_t        psp_q, psp_d, rsp_q, rsp_d;

  logic [15:0] insn, n, r, rval, alu;
  logic [1:0]  pact, ract;
  logic        dwrite;

  // Same action encoding for both stacks; a push lands on the incremented pointer.
  function automatic ptr_t step_ptr(ptr_t p, logic [1:0] act);
    case (act)
      2'b01:   return p - ptr_t'(1);
      2'b11:   return p + ptr_t'(1);
      default: return p;
    endcase
  endfunction

  assign insn   = bus.idata;
  assign n      = pstack[psp_q];
  assign r      = rstack[rsp_q];
  assign ip_inc = ip_q + 10'd1;

  always_comb begin
    alu = ~t_q;
    case (insn[2:0])
      3'b000:  alu = ~t_q;
      3'b001:  alu = {t_q[15], t_q[15:1]};
      3'b010:  alu = {16{t_q == 16'd0}};
      3'b011:  alu = 16'd0 - t_q;
      3'b100:  alu = n & t_q;
      3'b101:  alu = n | t_q;
      3'b110:  alu = n ^ t_q;
      default: alu = n + t_q;
    endcase
  end

  always_comb begin
    ip_d   = ip_inc;
    t_d    = t_q;
    pact   = 2'b00;
    ract   = 2'b00;
    rval   = t_q;
    dwrite = 1'b0;
    if (!insn[15]) begin
      pact = 2'b11;
      t_d  = {1'b0, insn[14:0]};
    end else begin
      case (insn[14:13])
        2'b00: begin
          pact = 2'b01;
          t_d  = n;
          if (t_q == 16'd0) ip_d = insn[9:0];
        end
        2'b01: ip_d = insn[9:0];
        2'b10: begin
          ract = 2'b11;
          rval = {6'd0, ip_inc};
          ip_d = insn[9:0];
        end
        default: begin
          pact = insn[3:2];
          case (insn[7:6])
            2'b00: t_d = alu;
            2'b01: begin
              if (insn[2:0] == 3'b011) t_d = bus.ddata_read;
              dwrite = (insn[2:0] == 3'b111);
            end
            2'b10:   t_d = n;
            default: t_d = r;
          endcase
          if (!insn[12]) begin
            ract = insn[5:4];
          end else if (insn[5:4] == 2'b11) begin
            ract = 2'b11;
            rval = {6'd0, ip_inc};
            ip_d = t_q[9:0];
          end else begin
            ract = 2'b01;
            ip_d = r[9:0];
          end
        end
      endcase
    end
    // The fetch cycle only primes the ROM pipeline; nothing may move.
    if (state_q == ST_FETCH) begin
      ip_d   = ip_q;
      t_d    = t_q;
      pact   = 2'b00;
      ract   = 2'b00;
      dwrite = 1'b0;
    end
  end

  assign psp_d = step_ptr(psp_q, pact);
  assign rsp_d = step_ptr(rsp_q, ract);

  assign bus.iaddr       = ip_d;
  assign bus.daddr       = t_q[7:0];
  assign bus.ddata_write = n;
  assign bus.dwrite      = dwrite;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      ip_q    <= '0;
      t_q     <= '0;
      psp_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= ST_EXEC;
      ip_q    <= ip_d;
      t_q     <= t_d;
      psp_q   <= psp_d;
      rsp_q   <= rsp_d;
    end
  end

  // Reset forces ST_FETCH asynchronously, which already suppresses both writes.
  always_ff @(posedge clk) begin
    if (pact[1]) pstack[psp_d] <= t_q;
    if (ract[1]) rstack[rsp_d] <= rval;
  end
endmodule

// File: tb/tb_forth_cpu.sv
// Self-checking bench for forth_cpu: directed program table, hand-written
// corner sequences and a random instruction stream against a reference model.
module tb_forth_cpu;
  logic clk   = 1'b0;
  logic reset = 1'b0;

  forth_cpu_if bus ();
  forth_cpu #(.SP_BITS(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ip, m_psp, m_rsp;
  logic [15:0] m_t;
  logic [15:0] m_ps [16];
  logic [15:0] m_rs [16];
  logic        m_dw;

  task automatic stack_op(input int which, input logic [1:0] act, input logic [15:0] v);
    int p;
    p = (which != 0) ? m_rsp : m_psp;
    if (act == 2'b01) p = (p + 15) % 16;
    else if (act == 2'b11) p = (p + 1) % 16;
    if (act[1]) begin
      if (which != 0) m_rs[p] = v;
      else m_ps[p] = v;
    end
    if (which != 0) m_rsp = p;
    else m_psp = p;
  endtask

  task automatic model_exec(input logic [15:0] ins, input logic [15:0] rd);
    logic [15:0] nv, rv, nt;
    int ret, nip;
    nv   = m_ps[m_psp];
    rv   = m_rs[m_rsp];
    ret  = (m_ip + 1) % 1024;
    nip  = ret;
    nt   = m_t;
    m_dw = 1'b0;
    if (!ins[15]) begin
      stack_op(0, 2'b11, m_t);
      nt = {1'b0, ins[14:0]};
    end else if (ins[14:13] == 2'd0) begin
      stack_op(0, 2'b01, m_t);
      nt = nv;
      if (m_t == 16'd0) nip = int'(ins[9:0]);
    end else if (ins[14:13] == 2'd1) begin
      nip = int'(ins[9:0]);
    end else if (ins[14:13] == 2'd2) begin
      stack_op(1, 2'b11, 16'(ret));
      nip = int'(ins[9:0]);
    end else begin
      case (ins[7:6])
        2'd0: case (ins[2:0])
          3'd0: nt = ~m_t;
          3'd1: nt = $signed(m_t) >>> 1;
          3'd2: nt = (m_t == 16'd0) ? 16'hFFFF : 16'h0000;
          3'd3: nt = 16'((65536 - int'(m_t)) % 65536);
          3'd4: nt = nv & m_t;
          3'd5: nt = nv | m_t;
          3'd6: nt = nv ^ m_t;
          default: nt = 16'((int'(nv) + int'(m_t)) % 65536);
        endcase
        2'd1: begin
          if (ins[2:0] == 3'd3) nt = rd;
          if (ins[2:0] == 3'd7) m_dw = 1'b1;
        end
        2'd2: nt = nv;
        default: nt = rv;
      endcase
      stack_op(0, ins[3:2], m_t);
      if (!ins[12]) begin
        stack_op(1, ins[5:4], m_t);
      end else if (ins[5:4] == 2'b11) begin
        stack_op(1, 2'b11, 16'(ret));
        nip = int'(m_t[9:0]);
      end else begin
        nip = int'(rv[9:0]);
        stack_op(1, 2'b01, 16'h0);
      end
    end
    m_t  = nt;
    m_ip = nip;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    bus.idata   = 16'hE047;
    bus.ddata_read = 16'h0;
    m_ip = 0; m_t = 16'h0; m_psp = 0; m_rsp = 0;
    #1;
    chk("rst.iaddr", 16'(bus.iaddr), 16'h0);
    chk("rst.dwrite", 16'(bus.dwrite), 16'h0);
    chk("rst.t", dut.t_q, 16'h0);
    chk("rst.psp", 16'(dut.psp_q), 16'h0);
    chk("rst.rsp", 16'(dut.rsp_q), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("fetch.dwrite", 16'(bus.dwrite), 16'h0);
    chk("fetch.iaddr", 16'(bus.iaddr), 16'h0);
    @(posedge clk);
    #1;
    chk("fetch.ip", 16'(dut.ip_q), 16'h0);
    chk("fetch.t", dut.t_q, 16'h0);
  endtask

  task automatic step(input string name, input logic [15:0] ins, input logic [15:0] rd);
    logic [7:0]  a0;
    logic [15:0] n0;
    @(negedge clk);
    bus.idata      = ins;
    bus.ddata_read = rd;
    a0 = m_t[7:0];
    n0 = m_ps[m_psp];
    model_exec(ins, rd);
    #1;
    chk({name, ".iaddr"}, 16'(bus.iaddr), 16'(m_ip));
    chk({name, ".dwrite"}, 16'(bus.dwrite), 16'(m_dw));
    chk({name, ".daddr"}, 16'(bus.daddr), 16'(a0));
    chk({name, ".dwdata"}, bus.ddata_write, n0);
    @(posedge clk);
    #1;
    chk({name, ".t"}, dut.t_q, m_t);
    chk({name, ".psp"}, 16'(dut.psp_q), 16'(m_psp));
    chk({name, ".rsp"}, 16'(dut.rsp_q), 16'(m_rsp));
    $display("step %-8s ins=%h ip=%03h t=%h psp=%0d rsp=%0d", name, ins, m_ip, m_t, m_psp, m_rsp);
  endtask

  task automatic init_step(input logic [15:0] ins);
    @(negedge clk);
    bus.idata      = ins;
    bus.ddata_read = 16'h0;
    model_exec(ins, 16'h0);
    @(posedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string            name;
    int               len;
    logic [0:5][15:0] prog;
    int               ip, psp, rsp;
    bit               t_en;
    logic [15:0]      t;
    int               ps_idx;
    logic [15:0]      ps_val;
    int               rs_idx;
    logic [15:0]      rs_val;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.idata      = 16'h0;
    bus.ddata_read = 16'h0;

    vecs[0]  = '{"brlit", 2, {16'hA064, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0}, 'h65, 1, 0, 1'b1, 16'h7FFF, -1, 16'h0, -1, 16'h0};
    vecs[1]  = '{"twolit", 2, {16'h1000, 16'h2000, 16'h0, 16'h0, 16'h0, 16'h0}, 2, 2, 0, 1'b1, 16'h2000, 2, 16'h1000, -1, 16'h0};
    vecs[2]  = '{"not", 2, {16'h7FFF, 16'hE000, 16'h0, 16'h0, 16'h0, 16'h0}, 2, 1, 0, 1'b1, 16'h8000, -1, 16'h0, -1, 16'h0};
    vecs[3]  = '{"asr", 3, {16'h7FFF, 16'hE000, 16'hE001, 16'h0, 16'h0, 16'h0}, 3, 1, 0, 1'b1, 16'hC000, -1, 16'h0, -1, 16'h0};
    vecs[4]  = '{"zeq", 2, {16'h0000, 16'hE002, 16'h0, 16'h0, 16'h0, 16'h0}, 2, 1, 0, 1'b1, 16'hFFFF, -1, 16'h0, -1, 16'h0};
    vecs[5]  = '{"neg", 2, {16'h0001, 16'hE003, 16'h0, 16'h0, 16'h0, 16'h0}, 2, 1, 0, 1'b1, 16'hFFFF, -1, 16'h0, -1, 16'h0};
    vecs[6]  = '{"add", 3, {16'h1234, 16'h5678, 16'hE007, 16'h0, 16'h0, 16'h0}, 3, 1, 0, 1'b1, 16'h68AC, -1, 16'h0, -1, 16'h0};
    vecs[7]  = '{"and", 3, {16'h1234, 16'h5678, 16'hE004, 16'h0, 16'h0, 16'h0}, 3, 1, 0, 1'b1, 16'h1230, -1, 16'h0, -1, 16'h0};
    vecs[8]  = '{"xor", 3, {16'h1234, 16'h5678, 16'hE006, 16'h0, 16'h0, 16'h0}, 3, 1, 0, 1'b1, 16'h444C, -1, 16'h0, -1, 16'h0};
    vecs[9]  = '{"rstk", 6, {16'h1234, 16'h5678, 16'h0ABC, 16'hE0B4, 16'hE084, 16'hE0DC}, 6, 2, 0, 1'b1, 16'h0ABC, 2, 16'h1234, -1, 16'h0};
    vecs[10] = '{"call", 1, {16'hC300, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 'h300, 0, 1, 1'b1, 16'h0000, -1, 16'h0, 1, 16'h0001};
    vecs[11] = '{"exec", 2, {16'h0300, 16'hF074, 16'h0, 16'h0, 16'h0, 16'h0}, 'h300, 0, 1, 1'b1, 16'h0300, -1, 16'h0, 1, 16'h0002};
    vecs[12] = '{"ret", 4, {16'h0300, 16'hE0B4, 16'h1234, 16'hF000, 16'h0, 16'h0}, 'h300, 1, 0, 1'b1, 16'hEDCB, -1, 16'h0, -1, 16'h0};

    // Fill both stack arrays so the model and the design agree on every entry.
    do_reset();
    for (int k = 0; k < 16; k++) init_step(16'(16'h0100 + k));
    for (int k = 0; k < 16; k++) init_step(16'hE0B4);

    for (int i = 0; i < 13; i++) begin
      do_reset();
      for (int j = 0; j < vecs[i].len; j++) step(vecs[i].name, vecs[i].prog[j], 16'h0);
      chk({vecs[i].name, ".IP"}, 16'(dut.ip_q), 16'(vecs[i].ip));
      chk({vecs[i].name, ".PSP"}, 16'(dut.psp_q), 16'(vecs[i].psp));
      chk({vecs[i].name, ".RSP"}, 16'(dut.rsp_q), 16'(vecs[i].rsp));
      if (vecs[i].t_en) chk({vecs[i].name, ".T"}, dut.t_q, vecs[i].t);
      if (vecs[i].ps_idx >= 0) chk({vecs[i].name, ".pstack"}, dut.pstack[vecs[i].ps_idx], vecs[i].ps_val);
      if (vecs[i].rs_idx >= 0) chk({vecs[i].name, ".rstack"}, dut.rstack[vecs[i].rs_idx], vecs[i].rs_val);
    end

    // 0BRANCH taken / not taken; T comes from the stack so only IP/PSP are fixed.
    do_reset();
    step("zb0", 16'h0000, 16'h0);
    step("zb0", 16'h8300, 16'h0);
    chk("zb0.IP", 16'(dut.ip_q), 16'h0300);
    chk("zb0.PSP", 16'(dut.psp_q), 16'h0);
    do_reset();
    step("zb1", 16'h0001, 16'h0);
    step("zb1", 16'h8300, 16'h0);
    chk("zb1.IP", 16'(dut.ip_q), 16'h0002);
    chk("zb1.PSP", 16'(dut.psp_q), 16'h0);

    // Store then fetch through the data port.
    do_reset();
    step("st", 16'h1234, 16'h0);
    step("st", 16'h0056, 16'h0);
    @(negedge clk);
    bus.idata      = 16'hE047;
    bus.ddata_read = 16'h0;
    model_exec(16'hE047, 16'h0);
    #1;
    chk("st.dwrite1", 16'(bus.dwrite), 16'h1);
    chk("st.daddr56", 16'(bus.daddr), 16'h0056);
    chk("st.wdata", bus.ddata_write, 16'h1234);
    @(posedge clk);
    #1;
    chk("st.PSP", 16'(dut.psp_q), 16'h1);
    step("ld", 16'hE043, 16'h2345);
    chk("ld.T", dut.t_q, 16'h2345);
    chk("ld.IP", 16'(dut.ip_q), 16'h0004);

    // Reset dropped mid-cycle must clear state without waiting for an edge.
    do_reset();
    step("abort", 16'h1234, 16'h0);
    step("abort", 16'h5678, 16'h0);
    @(negedge clk);
    bus.idata = 16'h7FFF;
    #2;
    reset = 1'b0;
    #1;
    chk("abort.ip", 16'(dut.ip_q), 16'h0);
    chk("abort.t", dut.t_q, 16'h0);
    chk("abort.psp", 16'(dut.psp_q), 16'h0);
    chk("abort.iaddr", 16'(bus.iaddr), 16'h0);
    chk("abort.dwrite", 16'(bus.dwrite), 16'h0);

    // Random instruction stream against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      step("rand", 16'($urandom()), 16'($urandom()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
